// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs op ID + register/immediate fields into a word, buffers it in a FIFO
// and streams it with incrementing word addresses. Define ENC_RANGE_CHECK_EN to reject out-of-range immediates.
module instr_encoder #(
    parameter int                FIFO_DEPTH = 4,
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_SH  = 3'd2;
    localparam logic [2:0] FMT_S   = 3'd3;
    localparam logic [2:0] FMT_B   = 3'd4;
    localparam logic [2:0] FMT_U   = 3'd5;
    localparam logic [2:0] FMT_J   = 3'd6;
    localparam logic [2:0] FMT_BUB = 3'd7;

    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic [31:0] encInstr;

    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W:0]    rdPtr_q, rdPtr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              full, empty, push, pop, accept;

    // Op ID to instruction format and the fixed opcode/funct bits
    always_comb begin
        fmt    = FMT_BUB;
        opcode = 7'h13;
        funct3 = 3'd0;
        funct7 = 7'h00;
        legal  = 1'b1;
        case (req_op)
            6'd0:  begin fmt = FMT_I;  opcode = 7'h03; funct3 = 3'd0; end
            6'd1:  begin fmt = FMT_I;  opcode = 7'h03; funct3 = 3'd1; end
            6'd2:  begin fmt = FMT_I;  opcode = 7'h03; funct3 = 3'd2; end
            6'd3:  begin fmt = FMT_I;  opcode = 7'h03; funct3 = 3'd4; end
            6'd4:  begin fmt = FMT_I;  opcode = 7'h03; funct3 = 3'd5; end
            6'd5:  begin fmt = FMT_S;  opcode = 7'h23; funct3 = 3'd0; end
            6'd6:  begin fmt = FMT_S;  opcode = 7'h23; funct3 = 3'd1; end
            6'd7:  begin fmt = FMT_S;  opcode = 7'h23; funct3 = 3'd2; end
            6'd8:  begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd1; end
            6'd9:  begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'd1; end
            6'd10: begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd5; end
            6'd11: begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'd5; end
            6'd12: begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd5; funct7 = 7'h20; end
            6'd13: begin fmt = FMT_SH; opcode = 7'h13; funct3 = 3'd5; funct7 = 7'h20; end
            6'd14: begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd0; end
            6'd15: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'd0; end
            6'd16: begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd0; funct7 = 7'h20; end
            6'd17: begin fmt = FMT_U;  opcode = 7'h37; end
            6'd18: begin fmt = FMT_U;  opcode = 7'h17; end
            6'd19: begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd4; end
            6'd20: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'd4; end
            6'd21: begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd6; end
            6'd22: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'd6; end
            6'd23: begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd7; end
            6'd24: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'd7; end
            6'd25: begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd2; end
            6'd26: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'd2; end
            6'd27: begin fmt = FMT_R;  opcode = 7'h33; funct3 = 3'd3; end
            6'd28: begin fmt = FMT_I;  opcode = 7'h13; funct3 = 3'd3; end
            6'd29: begin fmt = FMT_B;  opcode = 7'h63; funct3 = 3'd0; end
            6'd30: begin fmt = FMT_B;  opcode = 7'h63; funct3 = 3'd1; end
            6'd31: begin fmt = FMT_B;  opcode = 7'h63; funct3 = 3'd4; end
            6'd32: begin fmt = FMT_B;  opcode = 7'h63; funct3 = 3'd5; end
            6'd33: begin fmt = FMT_B;  opcode = 7'h63; funct3 = 3'd6; end
            6'd34: begin fmt = FMT_B;  opcode = 7'h63; funct3 = 3'd7; end
            6'd35: begin fmt = FMT_J;  opcode = 7'h6F; end
            6'd36: begin fmt = FMT_I;  opcode = 7'h67; funct3 = 3'd0; end
            6'd37: fmt = FMT_BUB;
            default: legal = 1'b0;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        case (fmt)
            FMT_I, FMT_S: if (req_imm[31:11] != {21{req_imm[11]}}) legal = 1'b0;
            FMT_B:  if (req_imm[31:12] != {20{req_imm[12]}} || req_imm[0]) legal = 1'b0;
            FMT_J:  if (req_imm[31:20] != {12{req_imm[20]}} || req_imm[0]) legal = 1'b0;
            FMT_SH: if (req_imm[31:5] != 27'd0) legal = 1'b0;
            FMT_U:  if (req_imm[11:0] != 12'd0) legal = 1'b0;
            default: ;
        endcase
`endif
    end

    // Field packing; fields a format does not use are left as zero
    always_comb begin
        encInstr = 32'h0000_0013;
        case (fmt)
            FMT_R:  encInstr = {funct7, req_rs2, req_rs1, funct3, req_rd, opcode};
            FMT_I:  encInstr = {req_imm[11:0], req_rs1, funct3, req_rd, opcode};
            FMT_SH: encInstr = {funct7, req_imm[4:0], req_rs1, funct3, req_rd, opcode};
            FMT_S:  encInstr = {req_imm[11:5], req_rs2, req_rs1, funct3, req_imm[4:0], opcode};
            FMT_B:  encInstr = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, funct3,
                                req_imm[4:1], req_imm[11], opcode};
            FMT_U:  encInstr = {req_imm[31:12], req_rd, opcode};
            FMT_J:  encInstr = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                                req_rd, opcode};
            default: encInstr = 32'h0000_0013;
        endcase
    end

    assign empty     = (wrPtr_q == rdPtr_q);
    assign full      = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                       (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
    assign req_ready = !full && !restart;
    assign accept    = req_valid && req_ready;
    assign push      = accept && legal;
    assign pop       = !empty && out_ready && !restart;

    assign out_valid   = !empty;
    assign out_instr   = empty ? 32'd0 : mem[rdPtr_q[PTR_W-1:0]];
    assign out_addr    = addr_q;
    assign err_illegal = err_q;

    // restart flushes everything; otherwise push/pop advance independently
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        addr_d  = addr_q;
        err_d   = err_q;
        if (restart) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            addr_d  = BASE_ADDR;
            err_d   = 1'b0;
        end else begin
            if (push)            wrPtr_d = wrPtr_q + 1'b1;
            if (pop)             rdPtr_d = rdPtr_q + 1'b1;
            if (pop)             addr_d  = addr_q + 1'b1;
            if (accept && !legal) err_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr_q[PTR_W-1:0]] <= encInstr;
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes hand-computed words, a monitor pops and compares.
module tb_instr_encoder;

    localparam int         ADDR_W = 2;
    localparam logic [1:0] BASE   = 2'd0;

    logic        clk = 1'b0;
    logic        reset, restart, req_valid, req_ready, out_valid, out_ready, err_illegal;
    logic [5:0]  req_op;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm, out_instr;
    logic [ADDR_W-1:0] out_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] expQ [$];
    logic [ADDR_W-1:0] expAddr;
    bit   bigImmLegal;

    instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, required);
        end
    endtask

    // Monitor: every word the sink takes must match the oldest expected word and address
    initial begin
        logic [31:0] e;
        expAddr = BASE;
        forever begin
            @(negedge clk);
            if (reset || restart) begin
                expAddr = BASE;
            end else if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_word actual=0x%08h required=none", out_instr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_instr", out_instr, e);
                    checkOutput("out_addr", 32'(out_addr), 32'(expAddr));
                end
                expAddr = expAddr + 1'b1;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge
    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm,
                                 input logic [31:0] expInstr, input bit isLegal);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_timeout actual=0 required=1");
        end else if (isLegal) begin
            expQ.push_back(expInstr);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    endtask

    task automatic doRestart();
        @(posedge clk);
        #1;
        restart = 1'b1;
        expQ.delete();
        @(negedge clk);
        checkOutput("ready_during_restart", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    initial begin
`ifdef ENC_RANGE_CHECK_EN
        bigImmLegal = 1'b0;
`else
        bigImmLegal = 1'b1;
`endif
        reset = 1'b1; restart = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
        req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        checkOutput("rst_out_addr", 32'(out_addr), 32'(BASE));
        checkOutput("rst_err", 32'(err_illegal), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic encodes, including first-word latency
        applyStimulus(6'd15, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
        @(negedge clk);
        checkOutput("latency_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(6'd29, 5'd0, 5'd1, 5'd2, 32'd8,  32'h0020_8463, 1'b1);
        applyStimulus(6'd37, 5'd0, 5'd0, 5'd0, 32'd0,  32'h0000_0013, 1'b1);
        applyStimulus(6'd35, 5'd1, 5'd0, 5'd0, 32'd16, 32'h0100_00EF, 1'b1);
        applyStimulus(6'd7,  5'd0, 5'd2, 5'd3, 32'd12, 32'h0031_2623, 1'b1);
        applyStimulus(6'd13, 5'd5, 5'd6, 5'd0, 32'd3,  32'h4033_5293, 1'b1);
        applyStimulus(6'd17, 5'd7, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_53B7, 1'b1);
        applyStimulus(6'd16, 5'd3, 5'd1, 5'd2, 32'd0,  32'h4020_81B3, 1'b1);
        applyStimulus(6'd31, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_CEE3, 1'b1);
        applyStimulus(6'd36, 5'd0, 5'd1, 5'd0, 32'd0,  32'h0000_8067, 1'b1);
        waitDrain();

        // Backpressure: fill, stall, drain
        doRestart();
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++)
            applyStimulus(6'd15, 5'd2, 5'd0, 5'd0, 32'(k), 32'h0000_0113 | (32'(k) << 20), 1'b1);
        req_valid = 1'b1; req_op = 6'd15; req_rd = 5'd2; req_imm = 32'd5;
        @(negedge clk);
        checkOutput("full_req_ready", 32'(req_ready), 32'd0);
        checkOutput("stall_instr", out_instr, 32'h0010_0113);
        checkOutput("stall_addr", 32'(out_addr), 32'd0);
        @(negedge clk);
        checkOutput("stall_instr_hold", out_instr, 32'h0010_0113);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("ready_before_pop", 32'(req_ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_after_pop", 32'(req_ready), 32'd1);
        waitDrain();

        // Illegal op and restart
        @(posedge clk);
        #1;
        applyStimulus(6'd45, 5'd1, 5'd1, 5'd1, 32'd1, 32'd0, 1'b0);
        @(negedge clk);
        checkOutput("illegal_no_valid", 32'(out_valid), 32'd0);
        checkOutput("illegal_err", 32'(err_illegal), 32'd1);
        doRestart();
        @(negedge clk);
        checkOutput("restart_err", 32'(err_illegal), 32'd0);
        checkOutput("restart_addr", 32'(out_addr), 32'(BASE));
        checkOutput("restart_valid", 32'(out_valid), 32'd0);

        // Out-of-range ADDI immediate
        @(posedge clk);
        #1;
        applyStimulus(6'd15, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093, bigImmLegal);
        @(negedge clk);
        checkOutput("bigimm_err", 32'(err_illegal), bigImmLegal ? 32'd0 : 32'd1);
        waitDrain();

        // Address wrap over 5 pops
        doRestart();
        for (int k = 0; k < 5; k++)
            applyStimulus(6'd24, 5'd4, 5'd3, 5'd0, 32'(k), 32'h0001_F213 | (32'(k) << 20), 1'b1);
        waitDrain();

        // Reset with words buffered discards them
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(6'd14, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1'b1);
        applyStimulus(6'd14, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1'b1);
        applyStimulus(6'd14, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0031_00B3, 1'b1);
        reset = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_addr", 32'(out_addr), 32'(BASE));
        checkOutput("midrst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("after_rst_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
